fetch_decode_queue: RTL and testbench



---
 rtl/fetch_decode_queue.sv | 92 +++++++++
 tb/tb_fetch_decode_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode: a small FIFO of {instr, pc} pairs with
// valid/ready on both sides and a single-cycle flush for branch/jump redirects.
module fetch_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_instr_i,
  input  logic [XLEN-1:0]          in_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_instr_o,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [XLEN-1:0]          out_pc_plus4_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [31:0]      instr_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem    [DEPTH];

  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  // Ready depends only on occupancy, so a full queue refuses a push even when popping.
  assign in_ready_o  = (count_q != Full);
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are masked by out_valid_o whenever they are stale.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= in_instr_i;
      pc_mem[wr_ptr_q]    <= in_pc_i;
    end
  end

  always_comb begin
    out_instr_o = NOP;
    out_pc_o    = '0;
    if (out_valid_o) begin
      out_instr_o = instr_mem[rd_ptr_q];
      out_pc_o    = pc_mem[rd_ptr_q];
    end
  end

  assign out_pc_plus4_o = out_pc_o + XLEN'(4);
  assign count_o        = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: vector table plus a FIFO scoreboard model,
// with hand-written sequences for reset and asynchronous reset while full.
module tb_fetch_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [2:0]  count;

  fetch_decode_queue #(
    .DEPTH(DEPTH),
    .XLEN (32),
    .NOP  (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_instr_i    (in_instr),
    .in_pc_i       (in_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_instr_o   (out_instr),
    .out_pc_o      (out_pc),
    .out_pc_plus4_o(out_pc_plus4),
    .count_o       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] instr;
    logic [31:0] pc;
    int          exp_count;
    string       tag;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  vec_t vecs[$];
  ent_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic ordy, input logic fl, input logic [31:0] instr,
                     input logic [31:0] pc, input int cnt, input string tag);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.instr = instr; v.pc = pc;
    v.exp_count = cnt; v.tag = tag;
    vecs.push_back(v);
  endtask

  // Compare every output against the scoreboard's view of the queue.
  task automatic check_outputs(input string tag);
    logic [31:0] e_instr, e_pc;
    e_instr = NOP;
    e_pc    = 32'h0;
    if (sb.size() != 0) begin
      e_instr = sb[0].instr;
      e_pc    = sb[0].pc;
    end
    chk({tag, ":count"},     32'(count),       32'(sb.size()));
    chk({tag, ":out_valid"}, 32'(out_valid),   32'(sb.size() != 0));
    chk({tag, ":in_ready"},  32'(in_ready),    32'(sb.size() != DEPTH));
    chk({tag, ":out_instr"}, out_instr,        e_instr);
    chk({tag, ":out_pc"},    out_pc,           e_pc);
    chk({tag, ":pc_plus4"},  out_pc_plus4,     e_pc + 32'd4);
  endtask

  task automatic step(input vec_t v);
    logic push_m, pop_m;
    in_valid  = v.iv;
    out_ready = v.ordy;
    flush     = v.fl;
    in_instr  = v.instr;
    in_pc     = v.pc;
    @(negedge clk);
    check_outputs(v.tag);
    push_m = v.iv && (sb.size() != DEPTH) && !v.fl;
    pop_m  = (sb.size() != 0) && v.ordy && !v.fl;
    @(posedge clk);
    #1;
    if (v.fl) begin
      sb.delete();
    end else begin
      if (pop_m) void'(sb.pop_front());
      if (push_m) sb.push_back('{instr: v.instr, pc: v.pc});
    end
    chk({v.tag, ":count_after"}, 32'(count), 32'(v.exp_count));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs("reset");
    chk("reset:nop", out_instr, 32'h0000_0013);
    chk("reset:plus4", out_pc_plus4, 32'h4);
    @(posedge clk);
    #1;

    // Two pushes, then drain.
    add(1, 0, 0, 32'h0050_0093, 32'h0, 1, "t2_push0");
    add(1, 0, 0, 32'h00A0_0113, 32'h4, 2, "t2_push1");
    add(0, 0, 0, 32'h0, 32'h0, 2, "t2_hold");
    add(0, 1, 0, 32'h0, 32'h0, 1, "t2_pop0");
    add(0, 1, 0, 32'h0, 32'h0, 0, "t2_pop1");
    // Fill, refused push while full with simultaneous pop, drain.
    for (int i = 0; i < 4; i++) add(1, 0, 0, 32'hA000_0000 + i, 32'h100 + 4 * i, i + 1, "t3_fill");
    add(1, 1, 0, 32'hEEEE_EEEE, 32'h200, 3, "t3_full_pop");
    for (int i = 0; i < 3; i++) add(0, 1, 0, 32'h0, 32'h0, 2 - i, "t3_drain");
    // Continuous streaming wraps the pointers.
    for (int i = 0; i < 10; i++) add(1, 1, 0, 32'hB000_0000 + i, 32'h400 + 4 * i, 1, "t4_stream");
    add(0, 1, 0, 32'h0, 32'h0, 0, "t4_drain");
    // Flush wins over simultaneous push and pop.
    for (int i = 0; i < 3; i++) add(1, 0, 0, 32'hC000_0000 + i, 32'h800 + 4 * i, i + 1, "t5_fill");
    add(1, 1, 1, 32'hDEAD_BEEF, 32'h900, 0, "t5_flush");
    add(1, 0, 0, 32'hC100_0000, 32'hA00, 1, "t5_push");
    add(0, 1, 0, 32'h0, 32'h0, 0, "t5_drain");
    // pc+4 wraps to zero.
    add(1, 0, 0, 32'h0000_0013, 32'hFFFF_FFFC, 1, "t6_wrap_push");
    add(0, 0, 0, 32'h0, 32'h0, 1, "t6_wrap_hold");
    add(0, 1, 0, 32'h0, 32'h0, 0, "t6_wrap_pop");
    for (int i = 0; i < 4; i++) add(1, 0, 0, 32'hF000_0000 + i, 32'hC00 + 4 * i, i + 1, "t6_fill");

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Asynchronous reset while full: takes effect before the next clock edge.
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst:count", 32'(count), 32'h0);
    chk("arst:out_valid", 32'(out_valid), 32'h0);
    chk("arst:in_ready", 32'(in_ready), 32'h1);
    chk("arst:out_instr", out_instr, NOP);
    chk("arst:plus4", out_pc_plus4, 32'h4);
    sb.delete();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    begin
      vec_t v;
      v.iv = 1'b1; v.ordy = 1'b0; v.fl = 1'b0; v.instr = 32'h1234_5678; v.pc = 32'h40;
      v.exp_count = 1; v.tag = "arst_recover";
      step(v);
      v.iv = 1'b0; v.ordy = 1'b1; v.exp_count = 0; v.tag = "arst_drain";
      step(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
